execute_muldiv: RTL and testbench
=================================

// Module: execute_muldiv
// PURPOSE
//  Multi-cycle integer multiply/divide unit for the execute stage (RV64M incl. W-forms).
//  Sits beside the single-cycle ALU path. Takes already-forwarded operands, iterates one
//  bit per cycle, and returns a result through a valid/ready handshake so the pipeline
//  can stall decode/execute while busy. Flushable on branch redirect.
// PARAMETERS
//  XLEN  64  datapath width; legal values 32 or 64 (W-forms only meaningful at 64)
// PORTS
//  clk        in   1     clock, rising edge
//  reset_n    in   1     asynchronous reset, active-low
//  in_valid   in   1     request present this cycle
//  in_ready   out  1     unit can accept a request
//  op         in   3     0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  word       in   1     W-variant: 32-bit operation, result sign-extended to XLEN
//  srca       in   XLEN  rs1 value (post-forwarding)
//  srcb       in   XLEN  rs2 value (post-forwarding)
//  flush      in   1     abandon any operation in flight
//  out_valid  out  1     result available
//  out_ready  in   1     consumer takes result this cycle
//  result     out  XLEN  final result
//  busy       out  1     state != IDLE (stall request to hazard unit)
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, counter=0.
//  FSM IDLE -> CALC on in_valid&&in_ready (operands/op/word latched that edge).
//      CALC -> DONE when iteration counter reaches N-1 (N=32 if word else XLEN).
//      DONE -> IDLE on out_ready. No acceptance in DONE (in_ready=0 outside IDLE).
//  Latency: accept at edge 0; out_valid=1 after N+1 edges; result held stable while
//      out_valid=1 && out_ready=0.
//  flush: from any state, next state IDLE, out_valid=0. flush && in_valid same cycle:
//      flush wins, request NOT accepted.
//  Operand prep: word=1 -> signed ops sign-extend bits[31:0], unsigned ops zero-extend.
//      Signed operands converted to magnitude; result sign fixed in the CALC->DONE step.
//  Multiply: shift-add, 2*N-bit product. MUL -> low N bits, MULH* -> high N bits.
//      MULHSU: srca signed, srcb unsigned.
//  Divide: restoring, one quotient bit per cycle. Quotient sign = sa^sb.
//      Remainder sign = dividend sign.
//  Divide by zero: quotient = all ones, remainder = dividend (N-bit view).
//  Signed overflow (min_int / -1): quotient = min_int, remainder = 0.
//  word=1: result = sign-extend(res[31:0]) for every op, including unsigned ones.
//  Counter wraps nowhere: it is cleared on accept; counts 0..N-1 only.
//  Reset asserted mid-CALC: immediate return to reset values; partial state discarded.
// CONFIGURATION
//  EXECUTE_MULDIV_FASTZERO_EN defined:
//      divide-by-zero and signed overflow detected at accept.
//      FSM goes IDLE -> DONE directly; out_valid after 1 edge.
//  Not defined: these cases iterate the full N cycles like any other divide.
//  Result values are identical either way; only latency differs.
// TESTING (XLEN=64)
//  MUL 7 x -3 -> result 0xFFFF_FFFF_FFFF_FFEB; out_valid exactly 65 edges after accept.
//  MULHU 0xFFFF..FF x 0xFFFF..FF -> 0xFFFF_FFFF_FFFF_FFFE;
//      MULHSU -1 x 2 -> 0xFFFF_FFFF_FFFF_FFFF.
//  DIVW 0x0000_0000_8000_0000 / -1 -> 0xFFFF_FFFF_8000_0000; REMW same operands -> 0.
//      Latency 33 edges.
//  DIVU 100 / 0 -> 0xFFFF_FFFF_FFFF_FFFF; REM -5 / 0 -> -5.
//      Latency 1 with FASTZERO_EN, 65 without.
//  DIV -7 / 2 -> -3, REM -7 / 2 -> -1; hold out_ready=0 5 cycles -> result stable, in_ready=0.
//  flush at CALC cycle 10 -> next cycle IDLE, in_ready=1, no out_valid.
//      flush+in_valid together -> nothing accepted.

Source files
------------

// File: rtl/execute_muldiv.sv
// execute_muldiv
//    Multi-cycle integer multiply/divide unit for the execute stage (RV64M
//    including the W-forms). It works on one bit per cycle: shift-add for
//    multiply and restoring division for divide. A result is returned through
//    a valid/ready handshake, and the unit can be flushed on a redirect.
//
// Parameters
//    XLEN       datapath width, 32 or 64 (W-forms only meaningful at 64)
//
// Ports
//    clk        clock, rising edge
//    reset_n    asynchronous reset, active low
//    in_valid   request present this cycle
//    in_ready   unit can accept a request (only while idle)
//    op         0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//    word       32-bit operation, result sign-extended to XLEN
//    srca/srcb  forwarded rs1/rs2 values
//    flush      abandon any operation in flight
//    out_valid  result available
//    out_ready  consumer takes the result this cycle
//    result     final result, held while out_valid && !out_ready
//    busy       unit is not idle (stall request)
//
// Configuration
//    EXECUTE_MULDIV_FASTZERO_EN  when defined, divide-by-zero and signed
//    overflow are resolved at accept and the result is ready one edge later.
//    The result values are the same; only the latency changes.

module execute_muldiv #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic            word,
   input  logic [XLEN-1:0] srca,
   input  logic [XLEN-1:0] srcb,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   localparam int CW  = $clog2(XLEN);
   localparam int WSH = XLEN - 32;

   state_e              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [2:0]          op_q, op_d;
   logic                word_q, word_d;
   logic                negRes_q, negRes_d;
   logic                negRem_q, negRem_d;
   logic                divZero_q, divZero_d;
   logic [XLEN-1:0]     opB_q, opB_d;
   logic [XLEN-1:0]     result_q, result_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;

   logic                signedA, signedB, isDivIn, aNeg, bNeg, divZeroIn;
   logic                accept, fastSpecial, lastIter;
   logic [XLEN-1:0]     aExt, bExt, aMag, bMag;

   logic [XLEN:0]       mulSum, divRem;
   logic                divGe;
   logic [XLEN-1:0]     divRest;
   logic [2*XLEN-1:0]   stepNext, prod, prodS;
   logic [XLEN-1:0]     quo, rem, rawRes, finalRes;

   // Operand preparation: take the N-bit view of each operand and turn the
   // signed ones into magnitudes; the signs are remembered for the final fixup.
   always_comb begin
      signedA   = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
      signedB   = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
      isDivIn   = op[2];
      if (word) begin
         aExt = signedA ? XLEN'($signed(srca[31:0])) : XLEN'(srca[31:0]);
         bExt = signedB ? XLEN'($signed(srcb[31:0])) : XLEN'(srcb[31:0]);
      end else begin
         aExt = srca;
         bExt = srcb;
      end
      aNeg      = signedA && aExt[XLEN-1];
      bNeg      = signedB && bExt[XLEN-1];
      aMag      = aNeg ? -aExt : aExt;
      bMag      = bNeg ? -bExt : bExt;
      divZeroIn = isDivIn && (bExt == '0);
      accept    = (state_q == IDLE) && in_valid && !flush;
      lastIter  = (cnt_q == (word_q ? CW'(31) : CW'(XLEN-1)));
   end

`ifdef EXECUTE_MULDIV_FASTZERO_EN
   logic            ovfIn;
   logic [XLEN-1:0] minInt, specRaw, specRes;

   // Divide-by-zero and min_int / -1 have fixed answers, so they skip the loop.
   always_comb begin
      minInt      = word ? XLEN'($signed(32'h8000_0000)) : {1'b1, {(XLEN-1){1'b0}}};
      ovfIn       = isDivIn && signedB && (aExt == minInt) && (bExt == '1);
      fastSpecial = divZeroIn || ovfIn;
      if (divZeroIn) specRaw = op[1] ? aExt : '1;
      else           specRaw = op[1] ? '0 : aExt;
      specRes     = word ? XLEN'($signed(specRaw[31:0])) : specRaw;
   end
`else
   assign fastSpecial = 1'b0;
`endif

   // One iteration step. The accumulator holds {hi, lo}: for multiply hi is the
   // running partial product and lo the multiplier being shifted out; for
   // divide hi is the partial remainder and lo the dividend/quotient shifter.
   always_comb begin
      mulSum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opB_q} : '0);
      divRem  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      divGe   = (divRem >= {1'b0, opB_q});
      divRest = divGe ? XLEN'(divRem - {1'b0, opB_q}) : divRem[XLEN-1:0];
      if (op_q[2]) stepNext = {divRest, acc_q[XLEN-2:0], divGe};
      else         stepNext = {mulSum, acc_q[XLEN-1:1]};
   end

   // Result assembly from the last step. A 32-bit multiply leaves its 64-bit
   // product shifted up by XLEN-32, so it is realigned before the sign fixup.
   always_comb begin
      prod  = word_q ? (stepNext >> WSH) : stepNext;
      prodS = negRes_q ? -prod : prod;
      quo   = divZero_q ? '1 :
              (negRes_q ? -stepNext[XLEN-1:0] : stepNext[XLEN-1:0]);
      rem   = negRem_q ? -stepNext[2*XLEN-1:XLEN] : stepNext[2*XLEN-1:XLEN];
      case (op_q)
         3'd0:             rawRes = prodS[XLEN-1:0];
         3'd1, 3'd2, 3'd3: rawRes = word_q ? XLEN'(prodS[63:32]) : prodS[2*XLEN-1:XLEN];
         3'd4, 3'd5:       rawRes = quo;
         default:          rawRes = rem;
      endcase
      finalRes = word_q ? XLEN'($signed(rawRes[31:0])) : rawRes;
   end

   // State and datapath registers; reset discards any partial computation.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         op_q      <= '0;
         word_q    <= 1'b0;
         negRes_q  <= 1'b0;
         negRem_q  <= 1'b0;
         divZero_q <= 1'b0;
         opB_q     <= '0;
         result_q  <= '0;
         acc_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         word_q    <= word_d;
         negRes_q  <= negRes_d;
         negRem_q  <= negRem_d;
         divZero_q <= divZero_d;
         opB_q     <= opB_d;
         result_q  <= result_d;
         acc_q     <= acc_d;
      end
   end

   // Next state: flush always wins, including over a same-cycle request.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid && !flush) state_d = fastSpecial ? DONE : CALC;
         CALC:    if (lastIter) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   // Datapath next values: latch the request on accept, iterate while in CALC.
   always_comb begin
      cnt_d     = cnt_q;
      op_d      = op_q;
      word_d    = word_q;
      negRes_d  = negRes_q;
      negRem_d  = negRem_q;
      divZero_d = divZero_q;
      opB_d     = opB_q;
      result_d  = result_q;
      acc_d     = acc_q;
      if (accept) begin
         cnt_d     = '0;
         op_d      = op;
         word_d    = word;
         negRes_d  = aNeg ^ bNeg;
         negRem_d  = aNeg;
         divZero_d = divZeroIn;
         opB_d     = isDivIn ? bMag : aMag;
         acc_d     = isDivIn ? {{XLEN{1'b0}}, aMag << (word ? WSH : 0)}
                             : {{XLEN{1'b0}}, bMag};
`ifdef EXECUTE_MULDIV_FASTZERO_EN
         if (fastSpecial) result_d = specRes;
`endif
      end else if ((state_q == CALC) && !flush) begin
         acc_d = stepNext;
         if (lastIter) result_d = finalRes;
         else          cnt_d    = cnt_q + 1'b1;
      end
   end

   // Handshake outputs decoded from the state.
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      busy      = (state_q != IDLE);
      result    = result_q;
   end

endmodule

// File: tb/tb_execute_muldiv.sv
// tb_execute_muldiv
//    Self-checking bench for execute_muldiv at XLEN=64. Expected results come
//    from a wide-arithmetic reference model of the RV64M rules.

module tb_execute_muldiv;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  op = 3'd0;
   logic        word = 1'b0;
   logic [63:0] srca = 64'd0;
   logic [63:0] srcb = 64'd0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] result;
   logic        busy;

   int vectors = 0;
   int miscompares = 0;

   execute_muldiv #(.XLEN(64)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .word(word), .srca(srca), .srcb(srcb), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
   );

   // Free-running clock, period 10
   always #5 clk = ~clk;

   // Reference result computed with 128-bit signed arithmetic on the N-bit view
   function automatic logic [63:0] refModel(input logic [2:0] o, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
      logic signed [127:0] as, au, bs, bu, p;
      logic [63:0] raw;
      as = w ? 128'($signed(a[31:0])) : 128'($signed(a));
      au = w ? 128'(a[31:0]) : 128'(a);
      bs = w ? 128'($signed(b[31:0])) : 128'($signed(b));
      bu = w ? 128'(b[31:0]) : 128'(b);
      p  = '0;
      case (o)
         3'd0: begin p = as * bs; raw = p[63:0]; end
         3'd1: begin p = as * bs; raw = w ? 64'(p[63:32]) : p[127:64]; end
         3'd2: begin p = as * bu; raw = w ? 64'(p[63:32]) : p[127:64]; end
         3'd3: begin p = au * bu; raw = w ? 64'(p[63:32]) : p[127:64]; end
         3'd4: begin
            if (bs == 0) raw = '1;
            else begin p = as / bs; raw = p[63:0]; end
         end
         3'd5: begin
            if (bu == 0) raw = '1;
            else begin p = au / bu; raw = p[63:0]; end
         end
         3'd6: begin
            if (bs == 0) p = as;
            else         p = as % bs;
            raw = p[63:0];
         end
         default: begin
            if (bu == 0) p = au;
            else         p = au % bu;
            raw = p[63:0];
         end
      endcase
      return w ? 64'($signed(raw[31:0])) : raw;
   endfunction

   // One comparison point
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one request, measure latency, check result, hold, then retire it
   task automatic applyStimulus(input logic [2:0] o, input logic w, input logic [63:0] a,
                                input logic [63:0] b, input int hold, output logic [63:0] got);
      int          edges;
      int          expLat;
      logic [63:0] exp;
      logic [63:0] held;
      exp    = refModel(o, w, a, b);
      expLat = w ? 33 : 65;
`ifdef EXECUTE_MULDIV_FASTZERO_EN
      if (o[2] && ((w ? (b[31:0] == 32'd0) : (b == 64'd0)) ||
          (((o == 3'd4) || (o == 3'd6)) &&
           (w ? ((a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF))
              : ((a == 64'h8000_0000_0000_0000) && (b == '1))))))
         expLat = 1;
`endif
      @(negedge clk);
      checkOutput("in_ready_idle", 64'(in_ready), 64'd1);
      in_valid = 1'b1; op = o; word = w; srca = a; srcb = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0; op = ~o; word = ~w; srca = ~a; srcb = ~b;
      edges = 1;
      @(negedge clk);
      while (!out_valid && edges < 200) begin
         @(negedge clk);
         edges++;
      end
      checkOutput("latency", 64'(edges), 64'(expLat));
      checkOutput("result", result, exp);
      checkOutput("in_ready_done", 64'(in_ready), 64'd0);
      checkOutput("busy_done", 64'(busy), 64'd1);
      got  = result;
      held = exp;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         checkOutput("hold_result", result, held);
         checkOutput("hold_valid", 64'(out_valid), 64'd1);
         checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("retire_valid", 64'(out_valid), 64'd0);
      checkOutput("retire_in_ready", 64'(in_ready), 64'd1);
   endtask

   initial begin
      logic [63:0] got;
      logic [63:0] a;
      logic [63:0] b;
      logic [2:0]  o;
      logic        w;
      logic        sawValid;

      // Reset values
      #12;
      checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_result", result, 64'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Directed cases with known answers
      applyStimulus(3'd0, 1'b0, 64'd7, -64'sd3, 0, got);
      checkOutput("MUL_7x-3", got, 64'hFFFF_FFFF_FFFF_FFEB);
      applyStimulus(3'd3, 1'b0, '1, '1, 0, got);
      checkOutput("MULHU_max", got, 64'hFFFF_FFFF_FFFF_FFFE);
      applyStimulus(3'd2, 1'b0, '1, 64'd2, 0, got);
      checkOutput("MULHSU_-1x2", got, 64'hFFFF_FFFF_FFFF_FFFF);
      applyStimulus(3'd4, 1'b1, 64'h0000_0000_8000_0000, '1, 0, got);
      checkOutput("DIVW_ovf", got, 64'hFFFF_FFFF_8000_0000);
      applyStimulus(3'd6, 1'b1, 64'h0000_0000_8000_0000, '1, 0, got);
      checkOutput("REMW_ovf", got, 64'd0);
      applyStimulus(3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 0, got);
      checkOutput("DIV_ovf", got, 64'h8000_0000_0000_0000);
      applyStimulus(3'd5, 1'b0, 64'd100, 64'd0, 0, got);
      checkOutput("DIVU_by0", got, 64'hFFFF_FFFF_FFFF_FFFF);
      applyStimulus(3'd6, 1'b0, -64'sd5, 64'd0, 0, got);
      checkOutput("REM_by0", got, -64'sd5);
      applyStimulus(3'd4, 1'b0, -64'sd7, 64'd2, 5, got);
      checkOutput("DIV_-7/2", got, -64'sd3);
      applyStimulus(3'd6, 1'b0, -64'sd7, 64'd2, 0, got);
      checkOutput("REM_-7/2", got, -64'sd1);

      // Flush in the middle of CALC
      @(negedge clk);
      in_valid = 1'b1; op = 3'd0; word = 1'b0; srca = 64'd123; srcb = 64'd456;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checkOutput("flush_busy", 64'(busy), 64'd0);
      checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
      checkOutput("flush_out_valid", 64'(out_valid), 64'd0);

      // Flush together with a request: nothing accepted
      flush = 1'b1; in_valid = 1'b1; op = 3'd4; srca = 64'd9; srcb = 64'd0;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      checkOutput("flushreq_busy", 64'(busy), 64'd0);
      sawValid = 1'b0;
      repeat (70) begin
         @(negedge clk);
         sawValid = sawValid | out_valid;
      end
      checkOutput("flush_no_valid", 64'(sawValid), 64'd0);

      // Asynchronous reset in the middle of CALC
      @(negedge clk);
      in_valid = 1'b1; op = 3'd1; word = 1'b0; srca = 64'd77; srcb = 64'd99;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (20) @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("midrst_busy", 64'(busy), 64'd0);
      checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
      checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("midrst_result", result, 64'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Randomized operations, biased toward the divide corner cases
      for (int k = 0; k < 40; k++) begin
         o = 3'($urandom_range(0, 7));
         w = 1'($urandom_range(0, 1));
         a = {$urandom(), $urandom()};
         b = {$urandom(), $urandom()};
         case ($urandom_range(0, 7))
            0: b = 64'd0;
            1: begin a = w ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000; b = '1; end
            2: b = 64'($urandom_range(1, 20));
            3: a = -64'($urandom_range(1, 1000));
            default: ;
         endcase
         applyStimulus(o, w, a, b, $urandom_range(0, 2), got);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
